// File: rtl/q_frame_accum.sv
`default_nettype none
//==============================================================================
// Module      : q_frame_accum
// Description : Frame accumulator for the three 3-bit result lanes of stage a.
//               Sums q1+q2+q3 over each sof..eof frame with saturation, counts
//               beats, force-closes long frames and emits one registered
//               result per frame. Orphan beats and restarts raise sticky flags.
// Revision    : 1.0 - initial release
//==============================================================================
module q_frame_accum #(
    parameter int BASE_W    = 18,
    parameter int CNT_W     = 8,
    parameter int MAX_BEATS = 200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        q1,
    input  logic [2:0]        q2,
    input  logic [2:0]        q3,
    input  logic              in_sof,
    input  logic              in_eof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BASE_W-1:0] out_base,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic              out_trunc,
    output logic              err_orphan,
    output logic              err_restart
);

    // Wide enough to hold a full-scale base plus one beat sum without wrapping.
    localparam int                c_wide_w     = ((BASE_W > 5) ? BASE_W : 5) + 1;
    localparam logic [BASE_W-1:0] c_base_max   = '1;
    localparam logic [CNT_W-1:0]  c_max_beats  = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0]  c_count_one  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t              r_state;
    logic [BASE_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_count;
    logic                r_sat;
    logic                r_out_valid;
    logic [BASE_W-1:0]   r_out_base;
    logic [CNT_W-1:0]    r_out_count;
    logic                r_out_sat;
    logic                r_out_trunc;
    logic                r_err_orphan;
    logic                r_err_restart;

    logic [4:0]          w_sum;
    logic [c_wide_w-1:0] w_acc_wide;
    logic [c_wide_w-1:0] w_first_wide;
    logic                w_acc_ovf;
    logic                w_first_ovf;
    logic [BASE_W-1:0]   w_acc_base;
    logic [BASE_W-1:0]   w_first_base;
    logic [CNT_W-1:0]    w_count_inc;
    logic                w_fire;

    // Beat sum, saturating running sum and the first-beat value of a new frame.
    always_comb begin
        w_sum        = {2'b00, q1} + {2'b00, q2} + {2'b00, q3};
        w_acc_wide   = c_wide_w'(r_base) + c_wide_w'(w_sum);
        w_first_wide = c_wide_w'(w_sum);
        w_acc_ovf    = (w_acc_wide > c_wide_w'(c_base_max));
        w_first_ovf  = (w_first_wide > c_wide_w'(c_base_max));
        w_acc_base   = w_acc_ovf ? c_base_max : w_acc_wide[BASE_W-1:0];
        w_first_base = w_first_ovf ? c_base_max : w_first_wide[BASE_W-1:0];
        w_count_inc  = r_count + c_count_one;
    end

    // A new beat is taken only when the result slot is free or being drained,
    // so an emit can never overwrite an unconsumed result.
    assign in_ready = !r_out_valid || out_ready;
    assign w_fire   = in_valid && in_ready;

    // Frame state machine with registered result and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_base        <= '0;
            r_count       <= '0;
            r_sat         <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_base    <= '0;
            r_out_count   <= '0;
            r_out_sat     <= 1'b0;
            r_out_trunc   <= 1'b0;
            r_err_orphan  <= 1'b0;
            r_err_restart <= 1'b0;
        end else begin
            // Drain first; an emit below in the same cycle takes precedence.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_fire) begin
                if (in_sof) begin
                    // Start (or restart) a frame; any partial frame is dropped.
                    if (r_state == ST_ACCUM) begin
                        r_err_restart <= 1'b1;
                    end
                    r_base  <= w_first_base;
                    r_count <= c_count_one;
                    r_sat   <= w_first_ovf;
                    if (in_eof || (c_max_beats == c_count_one)) begin
                        r_out_valid <= 1'b1;
                        r_out_base  <= w_first_base;
                        r_out_count <= c_count_one;
                        r_out_sat   <= w_first_ovf;
                        r_out_trunc <= !in_eof;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_ACCUM;
                    end
                end else if (r_state == ST_ACCUM) begin
                    r_base  <= w_acc_base;
                    r_count <= w_count_inc;
                    r_sat   <= r_sat | w_acc_ovf;
                    if (in_eof || (w_count_inc == c_max_beats)) begin
                        r_out_valid <= 1'b1;
                        r_out_base  <= w_acc_base;
                        r_out_count <= w_count_inc;
                        r_out_sat   <= r_sat | w_acc_ovf;
                        r_out_trunc <= !in_eof;
                        r_state     <= ST_IDLE;
                    end
                end else begin
                    // Beat outside any frame: discarded.
                    r_err_orphan <= 1'b1;
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_base    = r_out_base;
    assign out_count   = r_out_count;
    assign out_sat     = r_out_sat;
    assign out_trunc   = r_out_trunc;
    assign err_orphan  = r_err_orphan;
    assign err_restart = r_err_restart;

endmodule
`default_nettype wire
